// File: rtl/mux8_pkg.sv
// Shared widths and FSM encoding for the 8:1-mux serialiser.
package mux8_pkg;
    localparam int WORD_W = 8;
    localparam int SEL_W  = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
endpackage

// File: rtl/mux.sv
// External 8:1 mux that the feeder drives through d/s; out is purely combinational.
module mux
    import mux8_pkg::*;
(
    input  logic [WORD_W-1:0] d,
    input  logic [SEL_W-1:0]  s,
    output logic              out
);
    assign out = d[s];
endmodule

// File: rtl/mux8_feeder.sv
// Serialises a parallel byte by sweeping the select of an external 8:1 mux,
// with valid/ready handshakes on both the word side and the bit side.
module mux8_feeder
    import mux8_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic [WORD_W-1:0] d,
    output logic [SEL_W-1:0]  s,
    input  logic              mux_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_bit,
    output logic              out_last
);
    localparam logic [SEL_W-1:0] S_START = MSB_FIRST ? 3'd7 : 3'd0;

    state_t           state;
    logic [SEL_W-1:0] beat;
    logic             accept_in;
    logic             accept_bit;

    // A new word may enter while the last bit of the current one is taken.
    assign in_ready   = rst_n && ((state == IDLE) || (out_last && out_ready));
    assign accept_in  = in_valid && in_ready;
    assign accept_bit = out_valid && out_ready;
    assign out_bit    = mux_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            d         <= '0;
            s         <= '0;
            beat      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (accept_in) begin
            state     <= SHIFT;
            d         <= in_data;
            s         <= S_START;
            beat      <= '0;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
        end else if (accept_bit) begin
            if (beat == 3'd7) begin
                // Word done with nothing queued: d and s keep their final values.
                state     <= IDLE;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                beat     <= beat + 3'd1;
                s        <= MSB_FIRST ? (s - 3'd1) : (s + 3'd1);
                out_last <= (beat == 3'd6);
            end
        end
    end
endmodule
